// File: rtl/register_file.sv
// Architectural integer register file with per-register rename tags.
// Combinational operand reads forward a same-cycle matching commit; x0 is hardwired to zero.
module register_file #(
    parameter int REG_NUM   = 32,
    parameter int REG_WIDTH = 5,
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rename_en,
    input  logic [REG_WIDTH-1:0] rename_rd,
    input  logic [ID_WIDTH-1:0]  rename_tag,
    input  logic                 commit_en,
    input  logic [REG_WIDTH-1:0] commit_rd,
    input  logic [VAL_WIDTH-1:0] commit_res,
    input  logic [ID_WIDTH-1:0]  commit_lab,
    input  logic                 flush_in,
    input  logic [REG_WIDTH-1:0] rs1,
    input  logic [REG_WIDTH-1:0] rs2,
    output logic [ID_WIDTH-1:0]  rf_label1,
    output logic [VAL_WIDTH-1:0] rf_val1,
    output logic [ID_WIDTH-1:0]  rf_label2,
    output logic [VAL_WIDTH-1:0] rf_val2
);

    logic [VAL_WIDTH-1:0] val_q   [REG_NUM];
    logic [VAL_WIDTH-1:0] val_d   [REG_NUM];
    logic [ID_WIDTH-1:0]  label_q [REG_NUM];
    logic [ID_WIDTH-1:0]  label_d [REG_NUM];

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = commit_en && (commit_rd != '0);
    assign rename_ok = rename_en && (rename_rd != '0);

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            val_d[i]   = val_q[i];
            label_d[i] = label_q[i];
        end
        if (rdy_in) begin
            if (commit_ok) begin
                val_d[commit_rd] = commit_res;
                // Only the matching producer releases the tag; a younger rename keeps ownership.
                if (label_q[commit_rd] == commit_lab) begin
                    label_d[commit_rd] = '0;
                end
            end
            if (flush_in) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    label_d[i] = '0;
                end
            end else if (rename_ok) begin
                label_d[rename_rd] = rename_tag;
            end
        end
        val_d[0]   = '0;
        label_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]   <= '0;
                label_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]   <= val_d[i];
                label_q[i] <= label_d[i];
            end
        end
    end

    logic fwd1;
    logic fwd2;

    // Same-cycle renames are never visible here; issue reads sources before its own rename lands.
    assign fwd1 = rdy_in && commit_en && (commit_rd == rs1) && (rs1 != '0)
                  && (label_q[rs1] == commit_lab);
    assign fwd2 = rdy_in && commit_en && (commit_rd == rs2) && (rs2 != '0)
                  && (label_q[rs2] == commit_lab);

    always_comb begin
        rf_label1 = label_q[rs1];
        rf_val1   = val_q[rs1];
        rf_label2 = label_q[rs2];
        rf_val2   = val_q[rs2];
        if (fwd1) begin
            rf_label1 = '0;
            rf_val1   = commit_res;
        end
        if (fwd2) begin
            rf_label2 = '0;
            rf_val2   = commit_res;
        end
        if (rs1 == '0) begin
            rf_label1 = '0;
            rf_val1   = '0;
        end
        if (rs2 == '0) begin
            rf_label2 = '0;
            rf_val2   = '0;
        end
    end

endmodule
